dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit directly downstream of the pipeline datapath's MEM stage. It consumes the EX/MEM outputs (ALU address, store data, access size) and drives a ready/valid data-memory bus.
- Generates byte enables and lane-aligned store data. Splits misaligned accesses into two word beats.
- Returns lane-0-aligned load data to the existing read-data sign/zero extender.
- Asserts a stall to the hazard unit until the access completes.

Parameters:
- ADDR_W, 32, address width (word-aligned bus address).
- DATA_W, 32, data width; fixed at 32, 4 byte lanes.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_memRead  in  1  MEM-stage load
- i_memWrite  in  1  MEM-stage store
- i_memSize  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- i_addr  in  32  byte address (MEM-stage ALU out)
- i_writeData  in  32  store data, lane 0 aligned
- o_stall  out  1  hold IF..MEM stages
- o_readData  out  32  load data shifted to lane 0, valid while in DONE
- o_misaligned  out  1  one-cycle pulse in DONE when the access was split
- o_req  out  1  bus request
- o_we  out  1  bus write
- o_addr  out  32  word-aligned bus address, bits [1:0] = 0
- o_wdata  out  32  bus write data
- o_be  out  4  byte enables
- i_gnt  in  1  request accepted this cycle
- i_rvalid  in  1  read data valid; arrives at least one cycle after gnt
- i_rdata  in  32  read data

Behaviour:
- Encodings: off = i_addr[1:0]; mask = 0001 / 0011 / 1111 by size; m8 = mask << off (8 bits). Split iff m8[7:4] != 0.
- Beat 0: addr = {i_addr[31:2], 00}, be = m8[3:0], wdata = i_writeData << 8*off.
- Beat 1: addr = {i_addr[31:2] + 1, 00}, with wrap-around 0xFFFFFFFC -> 0x00000000; be = m8[7:4], wdata = i_writeData >> 8*(4-off).
- FSM states: IDLE, WAIT0, REQ1, WAIT1, DONE. Registered state; bus outputs are combinational from state and inputs.
- IDLE:
  - If i_memRead | i_memWrite: o_req = 1 with beat 0, o_stall = 1.
  - Both read and write high: treat as a write.
  - On i_gnt: store non-split -> DONE; store split -> REQ1; load -> WAIT0.
  - No gnt: stay in IDLE; hold the request, since the inputs are stable under stall.
- WAIT0: o_stall = 1, o_req = 0. On i_rvalid, capture i_rdata into lo. Non-split -> DONE; split -> REQ1.
- REQ1: o_req = 1 with beat 1, o_stall = 1. On i_gnt: store -> DONE; load -> WAIT1.
- WAIT1: o_stall = 1. On i_rvalid, capture i_rdata into hi, then -> DONE.
- DONE:
  - o_stall = 0 and o_req = 0; the pipeline advances at the end of this cycle.
  - o_readData = ({hi, lo} >> 8*off)[31:0]. Upper bits are not masked; the extender applies the size.
  - o_misaligned = split.
  - Next state IDLE unconditionally. The still-asserted i_memRead/i_memWrite of the retiring instruction is ignored.
- No access in IDLE: o_stall = 0, o_req = 0.
- Latency, counted from the MEM-stage entry cycle to the DONE cycle inclusive:
  - aligned store, immediate gnt: 2 cycles
  - aligned load, gnt immediate, rvalid at gnt+1: 3 cycles
  - split load: 5 cycles
- Outputs hold: lo, hi and o_readData hold their value outside DONE. Reset value is 0.
- i_rvalid outside WAIT0/WAIT1 is ignored.
- Reset values: state IDLE, lo = hi = 0, o_misaligned = 0, o_req = 0, o_stall = 0.
- Reset mid-operation: aborts to IDLE next cycle. An outstanding rvalid from the aborted access is ignored.
- o_we = i_memWrite (write-priority rule applied) whenever o_req = 1.

Decomposition:
- Package lsu_pkg:
  - state enum
  - size constants MEM_BYTE = 2'b00, MEM_HALF = 2'b01, MEM_WORD = 2'b10
  - lane-mask function
- Sub-module lsu_lane_align (combinational): computes m8, split flag, both beat addresses, be and wdata, and the load combine/shift.

Test Plan:
- Aligned SW: addr 0x1000, data 0xDEADBEEF, gnt immediate -> one req: be 1111, o_addr 0x1000, wdata 0xDEADBEEF, we = 1. Stall for 1 cycle, DONE on cycle 2.
- SB at 0x1003, data 0x000000AB -> be 1000, wdata 0xAB000000, no split, o_misaligned = 0.
- LW at 0x2002: beat 0 returns 0x44332211, beat 1 returns 0x88776655 -> addrs 0x2000 then 0x2004, o_readData 0x66554433, o_misaligned pulse 1. Total 5 cycles with gnt immediate, rvalid+1.
- SH at 0x2003, data 0x0000CAFE -> beat 0 be 1000 wdata 0xFE000000; beat 1 be 0001 wdata 0x000000CA, addr 0x2004.
- Word load at 0xFFFFFFFE -> beat 1 addr 0x00000000. gnt withheld 3 cycles on each beat -> o_req stays high and o_stall = 1 throughout, request values stable.
- Reset asserted in WAIT0, then a late rvalid -> state IDLE, o_stall = 0, o_readData unchanged (0). A back-to-back LW/SW pair executes both accesses exactly once.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - lsu_state_e : access sequencing states
//   - MEM_BYTE / MEM_HALF / MEM_WORD : MEM-stage access size encodings
//   - lane_mask() : byte-lane mask of an access of a given size at lane 0
// -----------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT0 = 3'd1,
      ST_REQ1  = 3'd2,
      ST_WAIT1 = 3'd3,
      ST_DONE  = 3'd4
   } lsu_state_e;

   // Reserved size 2'b11 behaves as a word access.
   function automatic logic [3:0] lane_mask(input logic [1:0] size);
      logic [3:0] mask;
      case (size)
         MEM_BYTE: mask = 4'b0001;
         MEM_HALF: mask = 4'b0011;
         default:  mask = 4'b1111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane steering for the load/store unit.
// Ports:
//   addr   : byte address of the access
//   size   : access size (byte / half / word)
//   wdata  : store data, lane-0 aligned
//   lo, hi : captured read words of beat 0 and beat 1
//   split  : access straddles a word boundary (two beats)
//   addr0/addr1 : word-aligned bus addresses of beat 0 / beat 1
//   be0/be1     : byte enables of beat 0 / beat 1
//   wdata0/wdata1 : lane-shifted store data of beat 0 / beat 1
//   rdata  : {hi, lo} shifted down to lane 0 (not size-masked)
// -----------------------------------------------------------------------------
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        size,
   input  logic [31:0]       wdata,
   input  logic [31:0]       lo,
   input  logic [31:0]       hi,
   output logic              split,
   output logic [ADDR_W-1:0] addr0,
   output logic [ADDR_W-1:0] addr1,
   output logic [3:0]        be0,
   output logic [3:0]        be1,
   output logic [31:0]       wdata0,
   output logic [31:0]       wdata1,
   output logic [31:0]       rdata
);

   logic [1:0] off_s;
   logic [7:0] m8_s;
   logic [4:0] sh_lo_s;
   logic [5:0] sh_hi_s;

   assign off_s   = addr[1:0];
   // Lanes 7..4 of the shifted mask belong to the following word.
   assign m8_s    = {4'b0000, lane_mask(size)} << off_s;
   assign split   = |m8_s[7:4];

   assign sh_lo_s = {off_s, 3'b000};
   // 32 - 8*off; a shift by 32 (off = 0) yields zero, which is what beat 1 needs.
   assign sh_hi_s = 6'd32 - {1'b0, off_s, 3'b000};

   assign addr0   = {addr[ADDR_W-1:2], 2'b00};
   // Natural (ADDR_W-2)-bit overflow gives the top-of-memory wrap to 0.
   assign addr1   = {addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};

   assign be0     = m8_s[3:0];
   assign be1     = m8_s[7:4];
   assign wdata0  = wdata << sh_lo_s;
   assign wdata1  = wdata >> sh_hi_s;

   // Low 32 bits of ({hi, lo} >> 8*off) without building the 64-bit value.
   assign rdata   = (lo >> sh_lo_s) | (hi << sh_hi_s);

endmodule

// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu
// Load/store unit between the MEM stage and a ready/valid data-memory bus.
// Splits word-straddling accesses into two beats and stalls the pipeline
// until the access has completed.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   i_memRead/i_memWrite/i_memSize/i_addr/i_writeData : MEM-stage request
//   o_stall            : hold IF..MEM while an access is in flight
//   o_readData         : lane-0 aligned load data (valid in DONE, held after)
//   o_misaligned       : pulse in DONE when the access took two beats
//   o_req/o_we/o_addr/o_wdata/o_be : bus request channel
//   i_gnt              : request accepted
//   i_rvalid/i_rdata   : read response channel
// -----------------------------------------------------------------------------
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_memRead,
   input  logic              i_memWrite,
   input  logic [1:0]        i_memSize,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_writeData,
   output logic              o_stall,
   output logic [DATA_W-1:0] o_readData,
   output logic              o_misaligned,
   output logic              o_req,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   output logic [3:0]        o_be,
   input  logic              i_gnt,
   input  logic              i_rvalid,
   input  logic [DATA_W-1:0] i_rdata
);

   lsu_state_e        state_r;
   lsu_state_e        state_nxt_s;
   logic [31:0]       lo_r;
   logic [31:0]       hi_r;
   logic [31:0]       rdata_hold_r;

   logic              access_s;
   logic              is_write_s;
   logic              split_s;
   logic [ADDR_W-1:0] addr0_s;
   logic [ADDR_W-1:0] addr1_s;
   logic [3:0]        be0_s;
   logic [3:0]        be1_s;
   logic [31:0]       wdata0_s;
   logic [31:0]       wdata1_s;
   logic [31:0]       rdata_s;

   // A simultaneous read and write is handled as a write.
   assign access_s   = i_memRead | i_memWrite;
   assign is_write_s = i_memWrite;

   lsu_lane_align #(
      .ADDR_W (ADDR_W)
   ) u_align (
      .addr   (i_addr),
      .size   (i_memSize),
      .wdata  (i_writeData),
      .lo     (lo_r),
      .hi     (hi_r),
      .split  (split_s),
      .addr0  (addr0_s),
      .addr1  (addr1_s),
      .be0    (be0_s),
      .be1    (be1_s),
      .wdata0 (wdata0_s),
      .wdata1 (wdata1_s),
      .rdata  (rdata_s)
   );

   // State register, read-beat capture and read-data hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         lo_r         <= 32'h0000_0000;
         hi_r         <= 32'h0000_0000;
         rdata_hold_r <= 32'h0000_0000;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_WAIT0) && i_rvalid) begin
            lo_r <= i_rdata;
         end
         if ((state_r == ST_WAIT1) && i_rvalid) begin
            hi_r <= i_rdata;
         end
         if (state_r == ST_DONE) begin
            rdata_hold_r <= rdata_s;
         end
      end
   end

   // Next-state sequencing of the one- or two-beat access.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (access_s && i_gnt) begin
               if (!is_write_s) begin
                  state_nxt_s = ST_WAIT0;
               end else if (split_s) begin
                  state_nxt_s = ST_REQ1;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT0: begin
            if (i_rvalid) begin
               state_nxt_s = split_s ? ST_REQ1 : ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT0;
            end
         end
         ST_REQ1: begin
            if (i_gnt) begin
               state_nxt_s = is_write_s ? ST_DONE : ST_WAIT1;
            end else begin
               state_nxt_s = ST_REQ1;
            end
         end
         ST_WAIT1: begin
            if (i_rvalid) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT1;
            end
         end
         ST_DONE: begin
            // The retiring instruction still drives the request; ignore it.
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Bus request channel and pipeline stall, decoded from state and inputs.
   always_comb begin
      o_req   = 1'b0;
      o_we    = 1'b0;
      o_stall = 1'b0;
      o_addr  = addr0_s;
      o_be    = be0_s;
      o_wdata = wdata0_s;
      case (state_r)
         ST_IDLE: begin
            if (access_s) begin
               o_req   = 1'b1;
               o_we    = is_write_s;
               o_stall = 1'b1;
            end else begin
               o_req   = 1'b0;
               o_stall = 1'b0;
            end
         end
         ST_WAIT0: begin
            o_stall = 1'b1;
         end
         ST_REQ1: begin
            o_req   = 1'b1;
            o_we    = is_write_s;
            o_stall = 1'b1;
            o_addr  = addr1_s;
            o_be    = be1_s;
            o_wdata = wdata1_s;
         end
         ST_WAIT1: begin
            o_stall = 1'b1;
         end
         ST_DONE: begin
            o_stall = 1'b0;
         end
         default: begin
            o_stall = 1'b0;
         end
      endcase
   end

   // Completion outputs: live in DONE, last completed value otherwise.
   always_comb begin
      if (state_r == ST_DONE) begin
         o_readData   = rdata_s;
         o_misaligned = split_s;
      end else begin
         o_readData   = rdata_hold_r;
         o_misaligned = 1'b0;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu
// Bench for dmem_lsu. The bench plays both the pipeline (MEM-stage request)
// and the data memory (byte-addressed store, grant / response delays).
// Expectations come from a byte-level view of each access: which byte
// addresses it touches, which words those fall in, and the stated latency.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_memRead;
   logic        i_memWrite;
   logic [1:0]  i_memSize;
   logic [31:0] i_addr;
   logic [31:0] i_writeData;
   logic        o_stall;
   logic [31:0] o_readData;
   logic        o_misaligned;
   logic        o_req;
   logic        o_we;
   logic [31:0] o_addr;
   logic [31:0] o_wdata;
   logic [3:0]  o_be;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   int n_checks = 0;
   int n_pass   = 0;

   // Memory contents, byte addressed; unwritten bytes read a fixed pattern.
   bit [7:0]  mem [bit [31:0]];
   bit [31:0] model_hi;
   bit [31:0] exp_hold;
   bit        hold_valid;
   bit [31:0] got;

   dmem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_memRead    (i_memRead),
      .i_memWrite   (i_memWrite),
      .i_memSize    (i_memSize),
      .i_addr       (i_addr),
      .i_writeData  (i_writeData),
      .o_stall      (o_stall),
      .o_readData   (o_readData),
      .o_misaligned (o_misaligned),
      .o_req        (o_req),
      .o_we         (o_we),
      .o_addr       (o_addr),
      .o_wdata      (o_wdata),
      .o_be         (o_be),
      .i_gnt        (i_gnt),
      .i_rvalid     (i_rvalid),
      .i_rdata      (i_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
      n_checks++;
      if (got_v === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
      end
   endtask

   function automatic bit [7:0] mem_byte(input bit [31:0] a);
      bit [7:0] v;
      if (mem.exists(a)) v = mem[a];
      else               v = a[7:0] ^ 8'h5A;
      return v;
   endfunction

   function automatic bit [31:0] mem_word(input bit [31:0] w);
      return {mem_byte(w + 32'd3), mem_byte(w + 32'd2), mem_byte(w + 32'd1), mem_byte(w)};
   endfunction

   task automatic preload_word(input bit [31:0] w, input bit [31:0] v);
      for (int k = 0; k < 4; k++) mem[w + k] = v[8*k +: 8];
   endtask

   // One pipeline access from MEM-stage entry until its DONE cycle retires.
   // gw: cycles the grant is withheld per beat; rw: extra cycles before rvalid.
   task automatic do_access(input bit rd, input bit wr, input bit [1:0] size,
                            input bit [31:0] a, input bit [31:0] wd,
                            input int gw, input int rw, output bit [31:0] got_rd);
      int        n, nbeats, exp_lat, cycles, beat, gwait, rwait, idx, d;
      bit        pending, split, done;
      bit [1:0]  off;
      bit [31:0] w0, w1, e, wcur, pend_w, exp_rd, ewd, bemask;
      bit [3:0]  ebe;

      n      = (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
      off    = a[1:0];
      w0     = a & 32'hFFFF_FFFC;
      e      = a + 32'(n) - 32'd1;
      w1     = e & 32'hFFFF_FFFC;
      split  = (w0 != w1);
      nbeats = split ? 2 : 1;
      exp_lat = wr ? (1 + nbeats + nbeats * gw) : (1 + 2 * nbeats + nbeats * (gw + rw));

      exp_rd = 32'h0;
      for (int j = 0; j < 4; j++) begin
         idx = int'(off) + j;
         if (idx < 4 || split) exp_rd[8*j +: 8] = mem_byte(a + 32'(j));
         else                  exp_rd[8*j +: 8] = model_hi[8*(idx-4) +: 8];
      end

      i_memRead = rd; i_memWrite = wr; i_memSize = size; i_addr = a; i_writeData = wd;
      beat = 0; gwait = gw; rwait = 0; pending = 1'b0; cycles = 0; done = 1'b0;
      pend_w = 32'h0; got_rd = 32'h0;

      while (!done && cycles < 60) begin
         @(negedge clk);
         cycles++;
         if (!o_stall) begin
            done = 1'b1;
            check("latency", cycles, exp_lat);
            check("beat_count", beat, nbeats);
            check("misaligned", o_misaligned, split);
            check("done_req", o_req, 1'b0);
            if (!wr) check("load_data", o_readData, exp_rd);
            got_rd = o_readData;
         end else if (o_req) begin
            if (beat >= nbeats) begin
               check("extra_beat", beat, nbeats - 1);
               i_gnt = 1'b1;
            end else begin
               wcur = (beat == 0) ? w0 : w1;
               ebe = 4'b0000; ewd = 32'h0; bemask = 32'h0;
               for (int k = 0; k < 4; k++) begin
                  d = int'(wcur + 32'(k) - a);
                  if (d >= 0 && d < n) begin
                     ebe[k] = 1'b1;
                     ewd[8*k +: 8] = wd[8*d +: 8];
                     bemask[8*k +: 8] = 8'hFF;
                  end
               end
               check("beat_addr", o_addr, wcur);
               check("beat_be", o_be, ebe);
               check("beat_we", o_we, wr);
               if (wr) check("beat_wdata", o_wdata & bemask, ewd);
               if (gwait > 0) begin
                  gwait--;
               end else begin
                  i_gnt = 1'b1;
                  beat++;
                  gwait = gw;
                  if (!wr) begin
                     pending = 1'b1; pend_w = wcur; rwait = rw;
                  end
               end
            end
         end else if (pending) begin
            if (rwait > 0) begin
               rwait--;
            end else begin
               i_rvalid = 1'b1; i_rdata = mem_word(pend_w); pending = 1'b0;
            end
         end
         @(posedge clk);
         #1;
         i_gnt = 1'b0; i_rvalid = 1'b0; i_rdata = $urandom;
      end
      if (!done) check("timeout_cycles", cycles, exp_lat);
      i_memRead = 1'b0; i_memWrite = 1'b0;

      if (wr) begin
         for (int j = 0; j < n; j++) mem[a + 32'(j)] = wd[8*j +: 8];
         hold_valid = 1'b0;
      end else begin
         if (split) model_hi = mem_word(w1);
         exp_hold   = exp_rd;
         hold_valid = 1'b1;
      end
   endtask

   // Pipeline bubble: no access, unit must be quiet and hold its read data.
   task automatic idle_cycle();
      i_memRead = 1'b0; i_memWrite = 1'b0;
      @(negedge clk);
      check("idle_stall", o_stall, 1'b0);
      check("idle_req", o_req, 1'b0);
      check("idle_misaligned", o_misaligned, 1'b0);
      if (hold_valid) check("idle_hold", o_readData, exp_hold);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit        rd, wr;
      bit [1:0]  sz;
      bit [31:0] a;
      int        kind;

      reset = 1'b1; i_memRead = 1'b0; i_memWrite = 1'b0; i_memSize = 2'b00;
      i_addr = 32'h0; i_writeData = 32'h0; i_gnt = 1'b0; i_rvalid = 1'b0; i_rdata = 32'h0;
      model_hi = 32'h0; exp_hold = 32'h0; hold_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_stall", o_stall, 1'b0);
      check("rst_req", o_req, 1'b0);
      check("rst_readdata", o_readData, 32'h0);
      check("rst_misaligned", o_misaligned, 1'b0);
      @(posedge clk); #1;

      // Reset while waiting for read data, then a stale rvalid arrives.
      i_memRead = 1'b1; i_memSize = 2'b10; i_addr = 32'h0000_3000;
      @(negedge clk);
      check("abort_req", o_req, 1'b1);
      i_gnt = 1'b1;
      @(posedge clk); #1;
      i_gnt = 1'b0;
      @(negedge clk);
      check("abort_wait0_stall", o_stall, 1'b1);
      check("abort_wait0_req", o_req, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; i_memRead = 1'b0; i_rvalid = 1'b1; i_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      check("abort_stall", o_stall, 1'b0);
      check("abort_req_idle", o_req, 1'b0);
      check("abort_readdata", o_readData, 32'h0);
      @(posedge clk); #1;
      i_rvalid = 1'b0;
      idle_cycle();

      // Directed cases
      preload_word(32'h0000_2000, 32'h4433_2211);
      preload_word(32'h0000_2004, 32'h8877_6655);
      do_access(1'b0, 1'b1, 2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, got);
      do_access(1'b0, 1'b1, 2'b00, 32'h0000_1003, 32'h0000_00AB, 0, 0, got);
      do_access(1'b1, 1'b0, 2'b10, 32'h0000_2002, 32'h0, 0, 0, got);
      check("lw_2002_literal", got, 32'h6655_4433);
      idle_cycle();
      do_access(1'b0, 1'b1, 2'b01, 32'h0000_2003, 32'h0000_CAFE, 0, 0, got);
      do_access(1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, 3, 0, got);
      idle_cycle();

      // Back-to-back load/store pair, then read back the store.
      do_access(1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0, 0, 0, got);
      check("lw_1000_literal", got, 32'hABAD_BEEF);
      do_access(1'b0, 1'b1, 2'b10, 32'h0000_1000, 32'h1234_5678, 0, 0, got);
      do_access(1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0, 0, 0, got);
      check("lw_after_sw", got, 32'h1234_5678);

      // Randomized traffic
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle_cycle();
         end else begin
            kind = $urandom_range(0, 2);
            rd = (kind != 1);
            wr = (kind != 0);
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h0000_4000 + 32'($urandom_range(0, 63));
            do_access(rd, wr, sz, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), got);
         end
      end
      idle_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
